// File: rtl/garage_pkg.sv
// garage_pkg: shared state encoding and default plant geometry for the garage door models
package garage_pkg;
  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPEN    = 3'd1,
    STOPPED = 3'd2,
    RISING  = 3'd3,
    FALLING = 3'd4,
    FAULT   = 3'd5
  } state_t;
  localparam int DEF_TRAVEL_STEPS = 8;
  localparam int DEF_STEP_DIV     = 4;
endpackage

// File: rtl/garage_step_prescaler.sv
// garage_step_prescaler: counts enabled cycles and pulses tick once every STEP_DIV of them
module garage_step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = enable & (cnt_q == CW'(STEP_DIV - 1));
    cnt_d = (clear | tick) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/garage_door_plant.sv
// garage_door_plant: door/limit-switch responder driven by motor commands.
// Define OBSTRUCTION_EN to add the Obstruct input and Obstructed flag.
module garage_door_plant
  import garage_pkg::*;
#(
  parameter  int TRAVEL_STEPS = DEF_TRAVEL_STEPS,
  parameter  int STEP_DIV     = DEF_STEP_DIV,
  localparam int POS_W        = $clog2(TRAVEL_STEPS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Up_M,
  input  logic             Dn_M,
`ifdef OBSTRUCTION_EN
  input  logic             Obstruct,
  output logic             Obstructed,
`endif
  output logic             Up_max,
  output logic             Dn_max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);
  localparam logic [POS_W-1:0] TOP = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] ONE = POS_W'(1);
  state_t           state_q, state_d, rest;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             both, up_req, dn_req, obs_hit, step_en, tick, at_top, at_bot;
`ifdef OBSTRUCTION_EN
  logic obstructed_q, obstructed_d;
  assign obs_hit      = (state_q == FALLING) & Obstruct & ~Up_M;
  assign dn_req       = Dn_M & ~Up_M & ~obstructed_q;
  assign obstructed_d = (up_req & ~Obstruct) ? 1'b0 : obs_hit ? 1'b1 : obstructed_q;
  assign Obstructed   = obstructed_q;
  always_ff @(posedge CLK) begin
    if (RST) obstructed_q <= 1'b0;
    else     obstructed_q <= obstructed_d;
  end
`else
  assign obs_hit = 1'b0;
  assign dn_req  = Dn_M & ~Up_M;
`endif
  assign both    = Up_M & Dn_M;
  assign up_req  = Up_M & ~Dn_M;
  assign at_top  = pos_q == TOP;
  assign at_bot  = pos_q == '0;
  assign rest    = at_bot ? CLOSED : at_top ? OPEN : STOPPED;
  // The prescaler only runs while the command keeps pushing in the current direction
  assign step_en = ~obs_hit & (((state_q == RISING) & up_req) | ((state_q == FALLING) & dn_req));
  garage_step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk    (CLK),
    .rst    (RST),
    .enable (step_en),
    .clear  (~step_en),
    .tick   (tick)
  );
  always_comb begin
    pos_d   = tick ? ((state_q == RISING) ? pos_q + 1'b1 : pos_q - 1'b1) : pos_q;
    state_d = state_q;
    if (both)
      state_d = FAULT;
    else if (state_q == FAULT)
      state_d = (Up_M | Dn_M) ? FAULT : rest;
    else if (obs_hit)
      state_d = STOPPED;
    else if (state_q == RISING)
      state_d = up_req ? ((tick && pos_q == TOP - ONE) ? OPEN : RISING)
              : dn_req ? (at_bot ? CLOSED : FALLING) : STOPPED;
    else if (state_q == FALLING)
      state_d = dn_req ? ((tick && pos_q == ONE) ? CLOSED : FALLING)
              : up_req ? (at_top ? OPEN : RISING) : STOPPED;
    else
      state_d = (up_req && !at_top) ? RISING : (dn_req && !at_bot) ? FALLING : state_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLOSED;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end
  assign Position = pos_q;
  assign Up_max   = at_top;
  assign Dn_max   = at_bot;
  assign Moving   = (state_q == RISING) | (state_q == FALLING);
  assign Fault    = state_q == FAULT;
endmodule

// File: tb/tb_garage_door_plant.sv
// tb_garage_door_plant: directed stimulus checked against a direction/position model every cycle
module tb_garage_door_plant;
  localparam int T  = 4;
  localparam int DV = 2;
  localparam int PW = $clog2(T + 1);
  logic clk = 1'b0, rst = 1'b1, up = 1'b0, dn = 1'b0, obs = 1'b0;
  logic up_max, dn_max, moving, fault;
  logic [PW-1:0] position;
`ifdef OBSTRUCTION_EN
  logic obstructed;
  localparam bit OBS_ON = 1'b1;
`else
  localparam bit OBS_ON = 1'b0;
`endif
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  typedef struct {
    int pos;
    int dir;
    int cnt;
    bit fault;
    bit obs;
  } mst_t;
  mst_t m;

  garage_door_plant #(.TRAVEL_STEPS(T), .STEP_DIV(DV)) dut (
    .CLK      (clk),
    .RST      (rst),
    .Up_M     (up),
    .Dn_M     (dn),
`ifdef OBSTRUCTION_EN
    .Obstruct (obs),
    .Obstructed(obstructed),
`endif
    .Up_max   (up_max),
    .Dn_max   (dn_max),
    .Position (position),
    .Moving   (moving),
    .Fault    (fault)
  );

  always #5 clk = ~clk;

  // Door as a direction of travel plus a cycle count toward the next step
  function automatic mst_t step(mst_t s, bit r, bit u, bit d, bit ob);
    mst_t n = s;
    int want;
    if (r) begin
      n.pos = 0; n.dir = 0; n.cnt = 0; n.fault = 0; n.obs = 0;
      return n;
    end
    if (u && !d && !ob) n.obs = 0;
    if (u && d) begin
      n.fault = 1; n.dir = 0; n.cnt = 0;
    end else if (s.fault) begin
      if (!u && !d) n.fault = 0;
    end else begin
      want = u ? 1 : (d && !s.obs) ? -1 : 0;
      if (OBS_ON && s.dir == -1 && ob && want != 1) begin
        n.obs = 1; n.dir = 0; n.cnt = 0;
      end else if (want == 0) begin
        n.dir = 0; n.cnt = 0;
      end else if (want != s.dir) begin
        n.cnt = 0;
        n.dir = ((want > 0) ? (s.pos < T) : (s.pos > 0)) ? want : 0;
      end else begin
        n.cnt = s.cnt + 1;
        if (n.cnt == DV) begin
          n.cnt = 0;
          n.pos = s.pos + s.dir;
          if (n.pos == 0 || n.pos == T) n.dir = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, up, dn, obs);

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("m_pos", int'(position), m.pos);
    chk("m_up_max", int'(up_max), int'(m.pos == T));
    chk("m_dn_max", int'(dn_max), int'(m.pos == 0));
    chk("m_moving", int'(moving), int'(m.dir != 0));
    chk("m_fault", int'(fault), int'(m.fault));
`ifdef OBSTRUCTION_EN
    chk("m_obstructed", int'(obstructed), int'(m.obs));
`endif
  end

  task automatic cyc(input bit u, input bit d, input bit r, input int n);
    repeat (n) begin
      up = u; dn = d; rst = r;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(0, 0, 1, 2);
    chk_on = 1'b1;
    chk("rst_pos", int'(position), 0);
    chk("rst_dn_max", int'(dn_max), 1);
    chk("rst_up_max", int'(up_max), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_fault", int'(fault), 0);
    cyc(1, 0, 0, 2);
    chk("up_e2_dn_max", int'(dn_max), 1);
    chk("up_e2_moving", int'(moving), 1);
    cyc(1, 0, 0, 1);
    chk("up_e3_dn_max", int'(dn_max), 0);
    chk("up_e3_pos", int'(position), 1);
    cyc(1, 0, 0, 6);
    chk("up_e9_pos", int'(position), 4);
    chk("up_e9_up_max", int'(up_max), 1);
    chk("up_e9_moving", int'(moving), 0);
    cyc(1, 0, 0, 1);
    chk("open_hold_pos", int'(position), 4);
    chk("open_hold_moving", int'(moving), 0);
    cyc(0, 1, 0, 3);
    chk("dn3_pos", int'(position), 3);
    chk("dn3_up_max", int'(up_max), 0);
    cyc(0, 0, 0, 1);
    chk("stop_pos", int'(position), 3);
    chk("stop_moving", int'(moving), 0);
    cyc(0, 1, 0, 3);
    cyc(1, 0, 0, 2);
    chk("pre_rev_pos", int'(position), 2);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    chk("rev_no_early_step", int'(position), 2);
    cyc(0, 1, 0, 1);
    chk("rev_step", int'(position), 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 3);
    cyc(0, 0, 0, 1);
    chk("pre_fault_pos", int'(position), 2);
    cyc(1, 1, 0, 5);
    chk("fault_flag", int'(fault), 1);
    chk("fault_pos", int'(position), 2);
    chk("fault_moving", int'(moving), 0);
    cyc(1, 0, 0, 1);
    chk("fault_single_cmd", int'(fault), 1);
    cyc(0, 0, 0, 1);
    chk("fault_clear", int'(fault), 0);
    chk("fault_clear_moving", int'(moving), 0);
    chk("fault_clear_pos", int'(position), 2);
    cyc(1, 0, 0, 3);
    chk("pre_rst_pos", int'(position), 3);
    cyc(1, 0, 1, 1);
    chk("mid_rst_pos", int'(position), 0);
    chk("mid_rst_dn_max", int'(dn_max), 1);
    chk("mid_rst_up_max", int'(up_max), 0);
    chk("mid_rst_moving", int'(moving), 0);
    cyc(0, 1, 0, 1);
    chk("dn_at_closed", int'(moving), 0);
    cyc(1, 0, 0, 9);
    cyc(0, 1, 0, 9);
    chk("full_close_pos", int'(position), 0);
    chk("full_close_moving", int'(moving), 0);
    chk("full_close_dn_max", int'(dn_max), 1);
`ifdef OBSTRUCTION_EN
    cyc(1, 0, 0, 9);
    cyc(0, 1, 0, 3);
    chk("obs_pre_pos", int'(position), 3);
    obs = 1'b1;
    cyc(0, 1, 0, 1);
    chk("obs_hit_moving", int'(moving), 0);
    chk("obs_hit_flag", int'(obstructed), 1);
    cyc(0, 1, 0, 3);
    chk("obs_dn_ignored", int'(moving), 0);
    chk("obs_dn_pos", int'(position), 3);
    obs = 1'b0;
    cyc(1, 0, 0, 1);
    chk("obs_clear_flag", int'(obstructed), 0);
    chk("obs_clear_moving", int'(moving), 1);
`endif
    cyc(0, 0, 0, 2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
